// File: rtl/arp_tx_scheduler.sv
// ARP transmit scheduler.
// Arbitrates ARP reply/request jobs onto a single ARP TX engine and runs the
// destination-MAC resolution FSM that gates the UDP transmit path.
// Build option: define ARP_RETRY_EN to re-issue unanswered ARP requests up to
// MAX_RETRIES times; without it the first timeout abandons resolution.
module arp_tx_scheduler #(
    parameter int unsigned RETRY_TIMEOUT = 156250,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic tx_axis_aclk,
    input  logic tx_axis_areset,
    input  logic arp_reply_req,
    output logic arp_reply_ack,
    input  logic arp_request_req,
    output logic arp_request_ack,
    output logic arp_tx_start,
    output logic arp_tx_op,
    input  logic arp_tx_busy,
    input  logic mac_exist,
    input  logic arp_reply_valid,
    input  logic udp_tx_req,
    output logic udp_tx_grant,
    output logic resolve_fail
);

    localparam int unsigned TIMER_W = (RETRY_TIMEOUT > 1) ? $clog2(RETRY_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RETRY_TIMEOUT - 1);

`ifdef ARP_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
`else
    // MAX_RETRIES has no effect in this build.
    localparam int unsigned max_retries_unused = MAX_RETRIES;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GRANT,
        S_FAIL
    } state_t;

    state_t              state_q;
    logic [TIMER_W-1:0]  timer_q;
`ifdef ARP_RETRY_EN
    logic [RETRY_W-1:0]  retry_q;
`endif
    logic                grant_q;
    logic                fail_q;

    logic                start_q;
    logic                op_q;
    logic                reply_ack_q;
    logic                request_ack_q;
    logic                last_op_q;

    logic                fsm_req;
    logic                slot;
    logic                request_pend;
    logic                issue_reply;
    logic                issue_request;

    // Arbitration decision for the next TX slot; alternates when the last op was a reply.
    always_comb begin
        fsm_req       = (state_q == S_REQ);
        request_pend  = arp_request_req | fsm_req;
        slot          = ~arp_tx_busy & ~start_q;
        issue_reply   = 1'b0;
        issue_request = 1'b0;
        if (slot) begin
            if (arp_reply_req && !(request_pend && last_op_q)) begin
                issue_reply = 1'b1;
            end else if (request_pend) begin
                issue_request = 1'b1;
            end
        end
    end

    // Registered start/opcode/acks; one request frame serves RX and the resolution FSM together.
    always_ff @(posedge tx_axis_aclk) begin
        if (tx_axis_areset) begin
            start_q       <= 1'b0;
            op_q          <= 1'b0;
            reply_ack_q   <= 1'b0;
            request_ack_q <= 1'b0;
            last_op_q     <= 1'b0;
        end else begin
            start_q       <= issue_reply | issue_request;
            op_q          <= issue_reply;
            reply_ack_q   <= issue_reply;
            request_ack_q <= issue_request & arp_request_req;
            if (issue_reply) begin
                last_op_q <= 1'b1;
            end else if (issue_request) begin
                last_op_q <= 1'b0;
            end
        end
    end

    // Resolution FSM with registered grant and failure pulse.
    always_ff @(posedge tx_axis_aclk) begin
        if (tx_axis_areset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
`ifdef ARP_RETRY_EN
            retry_q <= '0;
`endif
            grant_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            grant_q <= 1'b0;
            fail_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (udp_tx_req) begin
                        if (mac_exist) begin
                            state_q <= S_GRANT;
                        end else begin
                            state_q <= S_REQ;
`ifdef ARP_RETRY_EN
                            retry_q <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    // Leave on the slot decision itself, so WAIT starts with the start pulse.
                    if (issue_request) begin
                        state_q <= S_WAIT;
                        timer_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (arp_reply_valid || mac_exist) begin
                        state_q <= S_GRANT;
                    end else if (timer_q == TIMER_LAST) begin
`ifdef ARP_RETRY_EN
                        if (retry_q < RETRY_LIMIT) begin
                            state_q <= S_REQ;
                            retry_q <= retry_q + 1'b1;
                        end else begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end
`else
                        state_q <= S_FAIL;
                        fail_q  <= 1'b1;
`endif
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!udp_tx_req) begin
                        state_q <= S_IDLE;
                    end else if (!mac_exist) begin
                        state_q <= S_REQ;
`ifdef ARP_RETRY_EN
                        retry_q <= '0;
`endif
                    end else begin
                        grant_q <= 1'b1;
                    end
                end
                S_FAIL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign arp_tx_start    = start_q;
    assign arp_tx_op       = op_q;
    assign arp_reply_ack   = reply_ack_q;
    assign arp_request_ack = request_ack_q;
    assign udp_tx_grant    = grant_q;
    assign resolve_fail    = fail_q;

endmodule
